// File: rtl/hazard_scheduler.sv
// hazard_scheduler: round-robin arbiter sharing the actuator bank and display
// among six home sensors. Optional macro: ALARM_PREEMPT_EN (fire alarm preempts).
module hazard_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int T_LOW       = 50,
  parameter int T_HIGH      = 70,
  parameter int CNT_W       = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SFA,
  input  logic       SW,
  input  logic [6:0] ST,
  input  logic       Ack,
  output logic [5:0] grant,
  output logic [2:0] display,
  output logic       busy,
  output logic [5:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  localparam logic [6:0] TLO = 7'(T_LOW);
  localparam logic [6:0] THI = 7'(T_HIGH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0] ALARM = 3'd2;

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       cur;
  logic [CNT_W-1:0] cnt;

  logic [5:0] req;
  logic [5:0] cand;
  logic [5:0] clr;
  logic [2:0] pick;
  logic       found;
  logic       end_svc;
  logic       preempt;

  assign req = {(ST > THI), (ST < TLO), SW, SFA, SRD, SFD};
  assign cand = pending | req;
  assign end_svc = Ack || (cnt == '0);

`ifdef ALARM_PREEMPT_EN
  assign preempt = (state == HOLD) && SFA && (cur != ALARM);
`else
  assign preempt = 1'b0;
`endif

  // first candidate at or after ptr, wrapping 5 -> 0
  always_comb begin
    logic [3:0] idx;
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int k = 0; k < 6; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'd6) idx = idx - 4'd6;
      if (!found && cand[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  // clear the finishing requester only on a normal end of service
  always_comb begin
    clr = '0;
    if (state == HOLD && !preempt && end_svc) clr = 6'b1 << cur;
  end

  // arbitration FSM with registered outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cur     <= '0;
      cnt     <= '0;
      grant   <= '0;
      display <= '0;
      busy    <= 1'b0;
      pending <= '0;
    end else begin
      pending <= (pending | req) & ~clr;
      unique case (state)
        IDLE, GAP: begin
          if (found) begin
            grant   <= 6'b1 << pick;
            display <= pick + 3'd1;
            busy    <= 1'b1;
            cnt     <= CNT_INIT;
            cur     <= pick;
            state   <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (preempt) begin
            grant   <= 6'b000100;
            display <= 3'd3;
            cnt     <= CNT_INIT;
            cur     <= ALARM;
          end else if (end_svc) begin
            ptr     <= (cur == 3'd5) ? 3'd0 : cur + 3'd1;
            grant   <= '0;
            display <= '0;
            busy    <= 1'b0;
            state   <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: vector table, directed sequences and random
// stimulus compared against a behavioural round-robin model.
module tb_hazard_scheduler;

  localparam int HOLD = 4;
  localparam int TL   = 50;
  localparam int TH   = 70;

  logic       Clk;
  logic       Rst;
  logic       sfd, srd, sfa, sw, ack;
  logic [6:0] st;
  logic [5:0] grant;
  logic [2:0] display;
  logic       busy;
  logic [5:0] pending;

  int n_cmp;
  int n_bad;

  // model state: who is served, cycles left, pointer, latched requests
  int       m_serv;
  int       m_rem;
  int       m_ptr;
  bit [5:0] m_pend;

  hazard_scheduler dut (
    .Clk(Clk), .Rst(Rst),
    .SFD(sfd), .SRD(srd), .SFA(sfa), .SW(sw),
    .ST(st), .Ack(ack),
    .grant(grant), .display(display),
    .busy(busy), .pending(pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [6:0] t;
    logic [2:0] disp;
    logic [5:0] gnt;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit [5:0] cur_req();
    int tv_i;
    tv_i = int'(st);
    return {tv_i > TH, tv_i < TL, sw, sfa, srd, sfd};
  endfunction

  task automatic model_reset();
    m_serv = -1;
    m_rem  = 0;
    m_ptr  = 0;
    m_pend = '0;
  endtask

  task automatic model_step();
    bit [5:0] r;
    bit [5:0] c;
    bit       pre;
    r = cur_req();
    if (m_serv >= 0) begin
      pre = 1'b0;
`ifdef ALARM_PREEMPT_EN
      pre = sfa && (m_serv != 2);
`endif
      if (pre) begin
        m_serv = 2;
        m_rem  = HOLD;
        m_pend = m_pend | r;
      end else if (ack || m_rem == 1) begin
        c = '0;
        c[m_serv] = 1'b1;
        m_pend = (m_pend | r) & ~c;
        m_ptr  = (m_serv + 1) % 6;
        m_serv = -1;
      end else begin
        m_rem  = m_rem - 1;
        m_pend = m_pend | r;
      end
    end else begin
      c = m_pend | r;
      for (int k = 0; k < 6; k++) begin
        if (m_serv < 0 && c[(m_ptr + k) % 6]) begin
          m_serv = (m_ptr + k) % 6;
          m_rem  = HOLD;
        end
      end
      m_pend = c;
    end
  endtask

  // one clock: advance model with present inputs, compare after the edge
  task automatic tick();
    logic [5:0] eg;
    logic [2:0] ed;
    model_step();
    @(posedge Clk);
    #1;
    eg = (m_serv >= 0) ? (6'b1 << m_serv) : 6'b0;
    ed = (m_serv >= 0) ? 3'(m_serv + 1) : 3'd0;
    chk("grant", 32'(grant), 32'(eg));
    chk("display", 32'(display), 32'(ed));
    chk("busy", 32'(busy), 32'(m_serv >= 0));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic quiet();
    sfd = 0; srd = 0; sfa = 0; sw = 0; ack = 0; st = 7'd60;
  endtask

  task automatic do_reset();
    quiet();
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Rst = 1'b1;
    model_reset();
  endtask

  int seq6[6];
  int alt[6];
  int nalt;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    do_reset();

    // async reset in the middle of an alarm service
    sfa = 1;
    tick();
    chk("t1_grant_alarm", 32'(grant), 32'h04);
    sfa = 0;
    tick();
    #3;
    Rst = 1'b0;
    #1;
    chk("t1_async_grant", 32'(grant), 32'd0);
    chk("t1_async_disp", 32'(display), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_pend", 32'(pending), 32'd0);
    #2;
    Rst = 1'b1;
    model_reset();
    repeat (3) tick();

    // single window pulse
    do_reset();
    sw = 1;
    tick();
    chk("t2_grant", 32'(grant), 32'h08);
    chk("t2_disp", 32'(display), 32'd4);
    sw = 0;
    repeat (3) begin
      tick();
      chk("t2_hold", 32'(display), 32'd4);
    end
    tick();
    chk("t2_gap", 32'(grant), 32'd0);
    chk("t2_pend3", 32'(pending[3]), 32'd0);
    tick();

    // threshold vectors
    tv[0] = '{7'd40,  3'd5, 6'b010000};
    tv[1] = '{7'd75,  3'd6, 6'b100000};
    tv[2] = '{7'd50,  3'd0, 6'b000000};
    tv[3] = '{7'd70,  3'd0, 6'b000000};
    tv[4] = '{7'd49,  3'd5, 6'b010000};
    tv[5] = '{7'd71,  3'd6, 6'b100000};
    tv[6] = '{7'd0,   3'd5, 6'b010000};
    tv[7] = '{7'd127, 3'd6, 6'b100000};
    tv[8] = '{7'd60,  3'd0, 6'b000000};
    tv[9] = '{7'd51,  3'd0, 6'b000000};
    for (int i = 0; i < 10; i++) begin
      quiet();
      st = tv[i].t;
      tick();
      chk($sformatf("tv%0d_disp", i), 32'(display), 32'(tv[i].disp));
      chk($sformatf("tv%0d_grant", i), 32'(grant), 32'(tv[i].gnt));
      st = 7'd60;
      repeat (5) tick();
    end

    // three requesters held: 1,2,4 rotation with one zero cycle between
    do_reset();
    sfd = 1; srd = 1; sw = 1;
    seq6 = '{1, 2, 4, 1, 2, 4};
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < HOLD; j++) begin
        tick();
        chk("t3_disp", 32'(display), 32'(seq6[i]));
      end
      tick();
      chk("t3_gap", 32'(display), 32'd0);
    end
    quiet();
    repeat (6) tick();

    // early end by acknowledge
    do_reset();
    srd = 1;
    tick();
    chk("t5_grant", 32'(display), 32'd2);
    srd = 0;
    tick();
    chk("t5_hold", 32'(display), 32'd2);
    ack = 1;
    tick();
    chk("t5_drop", 32'(grant), 32'd0);
    chk("t5_pend1", 32'(pending[1]), 32'd0);
    ack = 0;
    tick();
    chk("t5_idle", 32'(busy), 32'd0);

    // alarm raised during a window service
    do_reset();
    sw = 1;
    tick();
    sw = 0;
    tick();
    sfa = 1;
`ifdef ALARM_PREEMPT_EN
    alt = '{3, 3, 3, 3, 0, 4};
    nalt = 6;
`else
    alt = '{4, 4, 0, 3, 0, 0};
    nalt = 4;
`endif
    for (int i = 0; i < nalt; i++) begin
      tick();
      sfa = 0;
      chk("t6_disp", 32'(display), 32'(alt[i]));
    end
    quiet();
    repeat (8) tick();

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      sfd = ($urandom % 4) == 0;
      srd = ($urandom % 4) == 0;
      sfa = ($urandom % 6) == 0;
      sw  = ($urandom % 4) == 0;
      ack = ($urandom % 10) == 0;
      if (($urandom % 8) == 0) st = 7'($urandom_range(0, 127));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
